// File: rtl/mux_scan_ctrl_if.sv
// Scan controller bus: request/mask/abort in, mux select out,
// mux bit back in, busy/done/result snapshot out.
interface mux_scan_ctrl_if #(
  parameter int NUM_CH = 10,
  parameter int SEL_W  = 4
);
  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] ch_mask;
  logic              mux_in;
  logic [SEL_W-1:0]  sel;
  logic              sel_valid;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] result;

  modport master (
    output start, abort, ch_mask, mux_in,
    input  sel, sel_valid, busy, done, result
  );

  modport slave (
    input  start, abort, ch_mask, mux_in,
    output sel, sel_valid, busy, done, result
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Walks a channel mux through the enabled channels of a mask, dwells,
// samples mux_in per channel into result; ports: clk, rst_n, bus.slave.
module mux_scan_ctrl #(
  parameter int NUM_CH = 10,
  parameter int SEL_W  = 4,
  parameter int DWELL  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    RELOAD = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] PARK   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] result_q, result_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SEL_W:0]    nxt;

  // {found, index} of the lowest set bit of m at or above 'from'
  function automatic logic [SEL_W:0] next_ch(
    input logic [NUM_CH-1:0] m,
    input int                from
  );
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    nxt         = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          result_d = '0;
          busy_d   = 1'b1;
          if (|bus.ch_mask) begin
            mask_d      = bus.ch_mask;
            nxt         = next_ch(bus.ch_mask, 0);
            sel_d       = nxt[SEL_W-1:0];
            sel_valid_d = 1'b1;
            cnt_d       = RELOAD;
            state_d     = S_DWELL;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DWELL: begin
        if (bus.abort) begin
          sel_d       = PARK;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == SEL_W'(k)) result_d[k] = bus.mux_in;
          end
          nxt = next_ch(mask_q, int'(sel_q) + 1);
          if (nxt[SEL_W]) begin
            sel_d = nxt[SEL_W-1:0];
            cnt_d = RELOAD;
          end else begin
            sel_d       = PARK;
            sel_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        sel_d       = PARK;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= PARK;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule
